// File: rtl/serial_rx.sv
// serial_rx: 8N1 asynchronous serial receiver.
// The rx line is synchronized, then sampled at the centre of each bit.
// A frame whose stop bit reads low raises frame_err. The receiver then
// waits in BREAK until the line returns high.
`timescale 1ns/1ps

module serial_rx #(
    parameter int CLK_PER_BIT = 50,
    parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT,
        BREAK
    } state_t;

    localparam logic [CTR_SIZE-1:0] HALF_TERM = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_SIZE-1:0] FULL_TERM = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [CTR_SIZE-1:0] CTR_ONE   = CTR_SIZE'(1);

    logic                rxMeta_q;
    logic                rxSync_q;
    state_t              state_q,     state_d;
    logic [CTR_SIZE-1:0] periodCtr_q, periodCtr_d;
    logic [2:0]          bitCtr_q,    bitCtr_d;
    logic [7:0]          shift_q,     shift_d;
    logic [7:0]          data_q,      data_d;
    logic                newData_q,   newData_d;
    logic                frameErr_q,  frameErr_d;
    logic                busy_q,      busy_d;

    // Two-flop synchronizer for the asynchronous line, reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // State, counter and output registers; the strobes and busy are registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            periodCtr_q <= '0;
            bitCtr_q    <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            newData_q   <= 1'b0;
            frameErr_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            periodCtr_q <= periodCtr_d;
            bitCtr_q    <= bitCtr_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            newData_q   <= newData_d;
            frameErr_q  <= frameErr_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: half a bit to reach the start-bit centre, then a full bit per sample.
    always_comb begin
        state_d     = state_q;
        periodCtr_d = periodCtr_q;
        bitCtr_d    = bitCtr_q;
        shift_d     = shift_q;
        data_d      = data_q;
        newData_d   = 1'b0;
        frameErr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                periodCtr_d = '0;
                bitCtr_d    = '0;
                if (!rxSync_q) begin
                    state_d = START_BIT;
                end
            end

            START_BIT: begin
                if (periodCtr_q == HALF_TERM) begin
                    periodCtr_d = '0;
                    if (rxSync_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    periodCtr_d = periodCtr_q + CTR_ONE;
                end
            end

            DATA: begin
                if (periodCtr_q == FULL_TERM) begin
                    periodCtr_d       = '0;
                    shift_d[bitCtr_q] = rxSync_q;
                    bitCtr_d          = bitCtr_q + 3'd1;
                    if (bitCtr_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end
                end else begin
                    periodCtr_d = periodCtr_q + CTR_ONE;
                end
            end

            STOP_BIT: begin
                if (periodCtr_q == FULL_TERM) begin
                    periodCtr_d = '0;
                    if (rxSync_q) begin
                        data_d    = shift_q;
                        newData_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = BREAK;
                    end
                end else begin
                    periodCtr_d = periodCtr_q + CTR_ONE;
                end
            end

            BREAK: begin
                periodCtr_d = '0;
                bitCtr_d    = '0;
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                periodCtr_d = '0;
                bitCtr_d    = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data      = data_q;
    assign new_data  = newData_q;
    assign frame_err = frameErr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx.
// Stimulus tasks drive 8N1 frames and queue the expected strobes.
// A negedge monitor pops the queue and checks every new_data and frame_err pulse.
`timescale 1ns/1ps

module tb_serial_rx;

    localparam int CPB      = 50;
    localparam int LATENCY  = CPB / 2 + 9 * CPB + 2;
    localparam int NUM_RAND = 100;

    typedef struct {
        bit         isErr;
        logic [7:0] value;
        longint     cycle;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       new_data;
    logic       frame_err;
    logic       busy;

    exp_t       expQ[$];
    longint     cycleCount;
    int         assertCount;
    int         failCount;
    logic [7:0] lastGood;

    serial_rx #(
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .new_data  (new_data),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to timestamp strobes against the expected latency.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    function automatic void checkOutput(input string name, input logic [63:0] actual,
                                        input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected,
                     cycleCount);
        end
    endfunction

    // Drives one bit period, starting and ending just after a rising edge.
    task automatic driveBit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idleLine(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame and, if requested, queues the strobe a correct receiver must give.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input bit expectIt);
        exp_t e;
        if (expectIt) begin
            e.cycle = cycleCount + 1 + LATENCY;
            if (stopBit) begin
                e.isErr  = 1'b0;
                e.value  = b;
                lastGood = b;
            end else begin
                e.isErr = 1'b1;
                e.value = lastGood;
            end
            expQ.push_back(e);
        end
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(b[i]);
        end
        driveBit(stopBit);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (new_data || frame_err) begin
            checkOutput("strobeExclusive", {62'd0, new_data, frame_err} == 64'd3, 64'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedStrobe", {62'd0, new_data, frame_err}, 64'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("strobeKind", {63'd0, frame_err}, {63'd0, e.isErr});
                checkOutput("data", {56'd0, data}, {56'd0, e.value});
                if (!e.isErr) begin
                    checkOutput("latency", cycleCount, e.cycle);
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #(10 * 95000);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint n;
        int     waitCycles;
        cycleCount  = 0;
        assertCount = 0;
        failCount   = 0;
        lastGood    = 8'h00;
        rst         = 1'b0;
        rx          = 1'b1;

        repeat (5) @(posedge clk);
        #1;
        checkOutput("resetData", {56'd0, data}, 64'd0);
        checkOutput("resetNewData", {63'd0, new_data}, 64'd0);
        checkOutput("resetFrameErr", {63'd0, frame_err}, 64'd0);
        checkOutput("resetBusy", {63'd0, busy}, 64'd0);
        rst = 1'b1;
        idleLine(10);

        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b1);
        idleLine(20);

        $display("[TB] false start");
        n = cycleCount;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("falseStartBusyHigh", {63'd0, busy}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        while (cycleCount < n + 1 + 27) @(posedge clk);
        #1;
        checkOutput("falseStartBusyLow", {63'd0, busy}, 64'd0);
        idleLine(30);

        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("breakBusy", {63'd0, busy}, 64'd1);
        checkOutput("breakDataKept", {56'd0, data}, 64'hA5);
        idleLine(10);
        checkOutput("afterBreakBusy", {63'd0, busy}, 64'd0);
        applyStimulus(8'h81, 1'b1, 1'b1);
        idleLine(20);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        applyStimulus(8'h55, 1'b1, 1'b1);
        idleLine(20);

        $display("[TB] reset during data bit 3");
        fork
            applyStimulus(8'hF8, 1'b1, 1'b0);
            begin
                repeat (199) @(posedge clk);
                #1;
                rst = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b1;
                lastGood = 8'h00;
                checkOutput("midResetData", {56'd0, data}, 64'd0);
                checkOutput("midResetNewData", {63'd0, new_data}, 64'd0);
                checkOutput("midResetFrameErr", {63'd0, frame_err}, 64'd0);
                checkOutput("midResetBusy", {63'd0, busy}, 64'd0);
            end
        join
        idleLine(20);
        applyStimulus(8'h12, 1'b1, 1'b1);
        idleLine(20);

        $display("[TB] random stream");
        for (int i = 0; i < NUM_RAND; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                idleLine($urandom_range(1, 2 * CPB));
            end
        end

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 2000) begin
            @(posedge clk);
            waitCycles++;
        end
        idleLine(5);
        checkOutput("pendingExpectations", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
